wb_fir_driver: RTL and testbench



---
 rtl/fir_wb_pkg.sv | 41 ++++
 rtl/wb_fir_driver_if.sv | 36 +++
 rtl/wb_master_port.sv | 64 ++++++
 rtl/wb_fir_driver.sv | 192 +++++++++++++++++++
 tb/tb_wb_fir_driver.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_wb_pkg.sv
// Shared definitions for the FIR accelerator Wishbone driver: register map,
// CTRL bit positions, sequencer state encoding and the bus request record.
package fir_wb_pkg;

  localparam logic [31:0] CTRL_OFS = 32'h0000_0000;
  localparam logic [31:0] TAP_OFS  = 32'h0000_0040;
  localparam logic [31:0] X_OFS    = 32'h0000_0080;
  localparam logic [31:0] Y_OFS    = 32'h0000_0084;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_TAP_WAIT = 4'd1;
  localparam state_t ST_TAP_WR   = 4'd2;
  localparam state_t ST_GO_WR    = 4'd3;
  localparam state_t ST_X_WAIT   = 4'd4;
  localparam state_t ST_X_WR     = 4'd5;
  localparam state_t ST_POLL_RD  = 4'd6;
  localparam state_t ST_Y_RD     = 4'd7;
  localparam state_t ST_Y_OUT    = 4'd8;
  localparam state_t ST_STOP_WR  = 4'd9;
  localparam state_t ST_FINISH   = 4'd10;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_req_t;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [31:0] ofs);
    return base + ofs;
  endfunction

  function automatic logic [31:0] ctrl_word(input logic start);
    return 32'(start) << CTRL_START_BIT;
  endfunction

endpackage

// File: rtl/wb_fir_driver_if.sv
// Wishbone classic single-beat bus between the FIR driver (master) and the
// accelerator register window (slave).
interface wb_fir_driver_if;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o,
    output wbm_stb_o,
    output wbm_we_o,
    output wbm_sel_o,
    output wbm_adr_o,
    output wbm_dat_o,
    input  wbm_dat_i,
    input  wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o,
    input  wbm_stb_o,
    input  wbm_we_o,
    input  wbm_sel_o,
    input  wbm_adr_o,
    input  wbm_dat_o,
    output wbm_dat_i,
    output wbm_ack_i
  );

endinterface

// File: rtl/wb_master_port.sv
// Single-beat Wishbone request/ack engine: latches one request, holds cyc/stb
// until ack or until the ack timeout expires.
module wb_master_port
  import fir_wb_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  bus_req_t       req_data,
  output logic           busy,
  output logic           rsp_valid,
  output logic           timeout,
  output logic [31:0]    rdata,
  wb_fir_driver_if.master wb
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic          cyc_q;
  logic          we_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [TW-1:0] timer_q;
  logic          ack_seen;

  // Ack only counts while our strobe is up; stray acks between cycles are ignored.
  assign ack_seen  = cyc_q & wb.wbm_ack_i;
  assign timeout   = cyc_q & ~wb.wbm_ack_i & (timer_q == TW'(ACK_TIMEOUT - 1));
  assign rsp_valid = ack_seen;
  assign rdata     = wb.wbm_dat_i;
  assign busy      = cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      timer_q <= '0;
    end else if (!cyc_q) begin
      if (req) begin
        cyc_q   <= 1'b1;
        we_q    <= req_data.we;
        adr_q   <= req_data.adr;
        dat_q   <= req_data.dat;
        timer_q <= '0;
      end
    end else if (ack_seen || timeout) begin
      cyc_q <= 1'b0;
    end else begin
      timer_q <= timer_q + TW'(1);
    end
  end

  assign wb.wbm_cyc_o = cyc_q;
  assign wb.wbm_stb_o = cyc_q;
  assign wb.wbm_we_o  = cyc_q & we_q;
  assign wb.wbm_sel_o = cyc_q ? 4'hF : 4'h0;
  assign wb.wbm_adr_o = adr_q;
  assign wb.wbm_dat_o = dat_q;

endmodule

// File: rtl/wb_fir_driver.sv
// FIR job sequencer: loads taps, starts the engine, then streams samples
// through the accelerator register window and forwards each result.
module wb_fir_driver
  import fir_wb_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          TAP_NUM     = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          LEN_W       = 16,
  parameter int          ACK_TIMEOUT = 255,
  parameter int          POLL_MAX    = 1023
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  cfg_start_i,
  input  logic [LEN_W-1:0]      cfg_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic                  tap_valid_i,
  output logic                  tap_ready_o,
  input  logic [DATA_WIDTH-1:0] tap_data_i,
  input  logic                  x_valid_i,
  output logic                  x_ready_o,
  input  logic [DATA_WIDTH-1:0] x_data_i,
  output logic                  y_valid_o,
  input  logic                  y_ready_i,
  output logic [DATA_WIDTH-1:0] y_data_o,
  wb_fir_driver_if.master       wbm
);

  localparam int KW = $clog2(TAP_NUM + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  state_t                state_q;
  logic [KW-1:0]         k_q;
  logic [LEN_W-1:0]      n_q;
  logic [LEN_W-1:0]      len_q;
  logic [PW-1:0]         poll_q;
  logic [DATA_WIDTH-1:0] y_q;
  logic                  err_q;

  logic                  req;
  bus_req_t              req_data;
  logic                  port_busy;
  logic                  rsp_valid;
  logic                  port_timeout;
  logic [31:0]           rdata;

  wb_master_port #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_port (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .req       (req),
    .req_data  (req_data),
    .busy      (port_busy),
    .rsp_valid (rsp_valid),
    .timeout   (port_timeout),
    .rdata     (rdata),
    .wb        (wbm)
  );

  // Stream-fed writes issue in the handshake cycle itself so the engine
  // captures the data; register-only accesses issue once the port is idle.
  always_comb begin
    req      = 1'b0;
    req_data = '{we: 1'b0, adr: 32'h0, dat: 32'h0};
    case (state_q)
      ST_TAP_WAIT: begin
        req      = tap_valid_i;
        req_data = '{we: 1'b1,
                     adr: reg_addr(BASE_ADDR, TAP_OFS + (32'(k_q) << 2)),
                     dat: 32'(tap_data_i)};
      end
      ST_GO_WR: begin
        req      = ~port_busy;
        req_data = '{we: 1'b1, adr: reg_addr(BASE_ADDR, CTRL_OFS), dat: ctrl_word(1'b1)};
      end
      ST_X_WAIT: begin
        req      = x_valid_i;
        req_data = '{we: 1'b1, adr: reg_addr(BASE_ADDR, X_OFS), dat: 32'(x_data_i)};
      end
      ST_POLL_RD: begin
        req      = ~port_busy;
        req_data = '{we: 1'b0, adr: reg_addr(BASE_ADDR, CTRL_OFS), dat: 32'h0};
      end
      ST_Y_RD: begin
        req      = ~port_busy;
        req_data = '{we: 1'b0, adr: reg_addr(BASE_ADDR, Y_OFS), dat: 32'h0};
      end
      ST_STOP_WR: begin
        req      = ~port_busy;
        req_data = '{we: 1'b1, adr: reg_addr(BASE_ADDR, CTRL_OFS), dat: ctrl_word(1'b0)};
      end
      default: begin
        req = 1'b0;
      end
    endcase
  end

  // A bus timeout overrides whatever the current state expected next.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      len_q   <= '0;
      poll_q  <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else if (port_timeout) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_start_i) begin
            state_q <= ST_TAP_WAIT;
            k_q     <= '0;
            n_q     <= '0;
            len_q   <= cfg_len_i;
            err_q   <= 1'b0;
          end
        end
        ST_TAP_WAIT: begin
          if (tap_valid_i) state_q <= ST_TAP_WR;
        end
        ST_TAP_WR: begin
          if (rsp_valid) begin
            k_q     <= k_q + KW'(1);
            state_q <= (k_q == KW'(TAP_NUM - 1)) ? ST_GO_WR : ST_TAP_WAIT;
          end
        end
        ST_GO_WR: begin
          if (rsp_valid) state_q <= (len_q == '0) ? ST_STOP_WR : ST_X_WAIT;
        end
        ST_X_WAIT: begin
          if (x_valid_i) state_q <= ST_X_WR;
        end
        ST_X_WR: begin
          if (rsp_valid) begin
            poll_q  <= '0;
            state_q <= ST_POLL_RD;
          end
        end
        ST_POLL_RD: begin
          if (rsp_valid) begin
            if (rdata[CTRL_DONE_BIT]) begin
              state_q <= ST_Y_RD;
            end else if (poll_q == PW'(POLL_MAX - 1)) begin
              state_q <= ST_IDLE;
              err_q   <= 1'b1;
            end else begin
              poll_q <= poll_q + PW'(1);
            end
          end
        end
        ST_Y_RD: begin
          if (rsp_valid) begin
            y_q     <= rdata[DATA_WIDTH-1:0];
            state_q <= ST_Y_OUT;
          end
        end
        ST_Y_OUT: begin
          if (y_ready_i) begin
            n_q     <= n_q + LEN_W'(1);
            state_q <= (n_q == len_q - LEN_W'(1)) ? ST_STOP_WR : ST_X_WAIT;
          end
        end
        ST_STOP_WR: begin
          if (rsp_valid) state_q <= ST_FINISH;
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_FINISH);
  assign err_o       = err_q;
  assign tap_ready_o = (state_q == ST_TAP_WAIT);
  assign x_ready_o   = (state_q == ST_X_WAIT);
  assign y_valid_o   = (state_q == ST_Y_OUT);
  assign y_data_o    = y_q;

endmodule

// File: tb/tb_wb_fir_driver.sv
// Directed bench for wb_fir_driver: a Wishbone slave model logs every acked
// access, which is compared against hand-built expected transaction tables.
module tb_wb_fir_driver;

  localparam int          DW      = 32;
  localparam int          TAPS    = 16;
  localparam int          LW      = 16;
  localparam int          ACK_TO  = 255;
  localparam int          POLL_MX = 1023;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [31:0] A_CTRL  = 32'h3000_0000;
  localparam logic [31:0] A_TAP   = 32'h3000_0040;
  localparam logic [31:0] A_X     = 32'h3000_0080;
  localparam logic [31:0] A_Y     = 32'h3000_0084;

  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; } bus_vec_t;
  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; int cyc; } log_t;
  typedef struct { logic [31:0] x; logic [31:0] y; int stall; } sample_vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [LW-1:0] cfg_len;
  logic          busy, done, err;
  logic          tap_valid, tap_ready;
  logic [DW-1:0] tap_data;
  logic          x_valid, x_ready;
  logic [DW-1:0] x_data;
  logic          y_valid, y_ready;
  logic [DW-1:0] y_data;

  wb_fir_driver_if bus ();

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  wb_fir_driver #(
    .DATA_WIDTH (DW),
    .TAP_NUM    (TAPS),
    .BASE_ADDR  (BASE),
    .LEN_W      (LW),
    .ACK_TIMEOUT(ACK_TO),
    .POLL_MAX   (POLL_MX)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .cfg_start_i (cfg_start),
    .cfg_len_i   (cfg_len),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .tap_valid_i (tap_valid),
    .tap_ready_o (tap_ready),
    .tap_data_i  (tap_data),
    .x_valid_i   (x_valid),
    .x_ready_o   (x_ready),
    .x_data_i    (x_data),
    .y_valid_o   (y_valid),
    .y_ready_i   (y_ready),
    .y_data_o    (y_data),
    .wbm         (bus)
  );

  // Slave model: registered one-cycle ack; CTRL reports done on the 4th poll
  // after each X write; Y reads return the sample table in order.
  logic        ack_r  = 1'b0;
  logic [31:0] rdat   = 32'h0;
  bit          ack_en = 1'b1;
  int          poll_n = 0;
  int          y_idx  = 0;
  int          cyc_no = 0;
  logic [31:0] y_slave [3];
  log_t        log_q [$];

  assign bus.wbm_ack_i = ack_r;
  assign bus.wbm_dat_i = ack_r ? rdat : 32'h0;

  always @(posedge clk) begin
    cyc_no <= cyc_no + 1;
    if (ack_r) begin
      log_q.push_back('{bus.wbm_we_o, bus.wbm_adr_o,
                        bus.wbm_we_o ? bus.wbm_dat_o : rdat, cyc_no});
      if (bus.wbm_we_o && bus.wbm_adr_o == A_X) poll_n <= 0;
      ack_r <= 1'b0;
    end else if (bus.wbm_cyc_o && bus.wbm_stb_o && ack_en) begin
      ack_r <= 1'b1;
      if (!bus.wbm_we_o && bus.wbm_adr_o == A_CTRL) begin
        rdat   <= (poll_n == 3) ? 32'h0000_0002 : 32'h0000_0000;
        poll_n <= poll_n + 1;
      end else if (!bus.wbm_we_o && bus.wbm_adr_o == A_Y) begin
        rdat  <= (y_idx < 3) ? y_slave[y_idx] : 32'hBAD0_BAD0;
        y_idx <= y_idx + 1;
      end else begin
        rdat <= 32'hDEAD_BEEF;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic recordFail(input string name);
    n_vec++;
    n_miss++;
    $display("[TB] FAIL %s: bounded wait expired or entry missing", name);
  endtask

  task automatic startJob(input logic [LW-1:0] len);
    cfg_len   = len;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic sendTap(input logic [31:0] d);
    int w = 0;
    tap_valid = 1'b1;
    tap_data  = d;
    while (!tap_ready && w < 600) begin @(negedge clk); w++; end
    if (!tap_ready) recordFail("tap_handshake");
    else @(negedge clk);
    tap_valid = 1'b0;
  endtask

  // One sample: push X, wait for the result, optionally stall the consumer.
  task automatic applyStimulus(input sample_vec_t v, input int idx);
    int w = 0;
    x_valid = 1'b1;
    x_data  = v.x;
    while (!x_ready && w < 600) begin @(negedge clk); w++; end
    if (!x_ready) begin
      recordFail("x_handshake");
      x_valid = 1'b0;
      return;
    end
    @(negedge clk);
    x_valid = 1'b0;
    y_ready = (v.stall == 0);
    w = 0;
    while (!y_valid && w < 6000) begin @(negedge clk); w++; end
    if (!y_valid) begin
      recordFail("y_valid_wait");
      y_ready = 1'b0;
      return;
    end
    checkOutput($sformatf("y_data_%0d", idx), 96'(y_data), 96'(v.y));
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      checkOutput($sformatf("y_stall_hold_%0d", i),
                  96'({y_valid, y_data, bus.wbm_cyc_o, x_ready, tap_ready}),
                  96'({1'b1, v.y, 3'b000}));
    end
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
  endtask

  task automatic waitDone(output int done_cnt);
    int w = 0;
    done_cnt = 0;
    while (busy && w < 6000) begin
      if (done) done_cnt++;
      @(negedge clk);
      w++;
    end
    if (busy) recordFail("job_end");
  endtask

  task automatic compareLog(input bus_vec_t exp[$], input int base, input string tag);
    checkOutput({tag, "_count"}, 96'(log_q.size() - base), 96'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < log_q.size())
        checkOutput($sformatf("%s_txn%0d", tag, i),
                    96'({log_q[base+i].we, log_q[base+i].adr, log_q[base+i].dat}),
                    96'({exp[i].we, exp[i].adr, exp[i].dat}));
      else
        recordFail($sformatf("%s_txn%0d", tag, i));
    end
  endtask

  sample_vec_t samples [3];
  bus_vec_t    exp_a [$];
  bus_vec_t    exp_b [$];
  int          base_a, base_b, dcnt, cnt;

  initial begin
    samples[0] = '{32'h0000_00A1, 32'h0000_0055, 0};
    samples[1] = '{32'h0000_00B2, 32'h0000_0066, 10};
    samples[2] = '{32'h0000_00C3, 32'h0000_0077, 0};
    for (int s = 0; s < 3; s++) y_slave[s] = samples[s].y;

    for (int k = 0; k < TAPS; k++) exp_a.push_back('{1'b1, A_TAP + 32'(4 * k), 32'(k + 1)});
    exp_a.push_back('{1'b1, A_CTRL, 32'h1});
    for (int s = 0; s < 3; s++) begin
      exp_a.push_back('{1'b1, A_X, samples[s].x});
      for (int p = 0; p < 4; p++) exp_a.push_back('{1'b0, A_CTRL, (p == 3) ? 32'h2 : 32'h0});
      exp_a.push_back('{1'b0, A_Y, samples[s].y});
    end
    exp_a.push_back('{1'b1, A_CTRL, 32'h0});

    for (int k = 0; k < TAPS; k++) exp_b.push_back('{1'b1, A_TAP + 32'(4 * k), 32'h1000 + 32'(k)});
    exp_b.push_back('{1'b1, A_CTRL, 32'h1});
    exp_b.push_back('{1'b1, A_CTRL, 32'h0});

    rst_n = 1'b0; cfg_start = 1'b0; cfg_len = '0;
    tap_valid = 1'b0; tap_data = '0; x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_bus", 96'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
                                  bus.wbm_adr_o, bus.wbm_dat_o}), 96'(0));
    checkOutput("reset_status", 96'({busy, done, err}), 96'(0));
    checkOutput("reset_streams", 96'({tap_ready, x_ready, y_valid, y_data}), 96'(0));
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] job A: 16 taps, 3 samples");
    base_a = log_q.size();
    startJob(16'd3);
    checkOutput("start_busy_tap_ready", 96'({busy, tap_ready, x_ready}), 96'(3'b110));
    for (int k = 0; k < TAPS; k++) sendTap(32'(k + 1));
    cfg_len = 16'd7; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; cfg_len = 16'd3;
    for (int s = 0; s < 3; s++) applyStimulus(samples[s], s);
    waitDone(dcnt);
    checkOutput("jobA_done_pulses", 96'(dcnt), 96'(1));
    checkOutput("jobA_end_status", 96'({busy, err, bus.wbm_cyc_o}), 96'(0));
    compareLog(exp_a, base_a, "jobA");
    if (log_q.size() > base_a + 1)
      checkOutput("tap_write_period", 96'(log_q[base_a+1].cyc - log_q[base_a].cyc), 96'(3));
    else
      recordFail("tap_write_period");

    $display("[TB] ack timeout");
    ack_en = 1'b0;
    startJob(16'd1);
    sendTap(32'h99);
    cnt = 0; dcnt = 0;
    while (bus.wbm_stb_o && cnt < 1000) begin
      if (done) dcnt++;
      cnt++;
      @(negedge clk);
    end
    checkOutput("stb_high_cycles", 96'(cnt), 96'(ACK_TO));
    checkOutput("timeout_status", 96'({err, busy, bus.wbm_cyc_o, tap_ready}), 96'(4'b1000));
    checkOutput("timeout_no_done", 96'(dcnt), 96'(0));
    ack_en = 1'b1;

    $display("[TB] job B: zero-length job clears error");
    base_b = log_q.size();
    startJob(16'd0);
    checkOutput("restart_clears_err", 96'({err, busy}), 96'(2'b01));
    for (int k = 0; k < TAPS; k++) sendTap(32'h1000 + 32'(k));
    waitDone(dcnt);
    checkOutput("jobB_done_pulses", 96'(dcnt), 96'(1));
    checkOutput("jobB_end_status", 96'({busy, err}), 96'(0));
    compareLog(exp_b, base_b, "jobB");

    $display("[TB] asynchronous reset during a bus cycle");
    ack_en = 1'b0;
    startJob(16'd2);
    sendTap(32'h5);
    checkOutput("pre_reset_stb", 96'({bus.wbm_cyc_o, bus.wbm_stb_o}), 96'(2'b11));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_drop", 96'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_sel_o, busy}), 96'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
